// File: rtl/cordic_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cordic_rr_scheduler: round-robin sharing of one iterative CORDIC core     |
// | among N_REQ QR-array PEs. Optional stats: define CORDIC_SCHED_STATS_EN.   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module cordic_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ITER  = 12,
  parameter int IDX_W = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mode_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             busy_o,
  output logic             core_start_o,
  output logic             core_mode_o,
  output logic [IDX_W-1:0] core_sel_o,
  output logic [CNT_W-1:0] iter_idx_o,
  output logic             core_last_o,
  output logic [N_REQ-1:0] done_o
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [15:0]      ops_cnt_o,
  output logic [15:0]      busy_cnt_o,
  output logic [15:0]      wait_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] PENULT   = CNT_W'(ITER - 2);
  localparam logic [IDX_W-1:0] MAX_SEL  = IDX_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             mode_q, mode_d;
  logic             start_q, start_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] req_hi;
  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_sel;
  logic             arb_mode;
  logic             arb_hit;

  // Circular search: lowest request at or above ptr wins, else lowest overall.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hi_mask[i] = (IDX_W'(i) >= ptr_q);
    end
    req_hi    = req_i & hi_mask;
    arb_hit   = |req_i;
    arb_grant = '0;
    arb_sel   = '0;
    arb_mode  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        arb_grant    = '0;
        arb_grant[i] = 1'b1;
        arb_sel      = IDX_W'(i);
        arb_mode     = mode_i[i];
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        arb_grant    = '0;
        arb_grant[i] = 1'b1;
        arb_sel      = IDX_W'(i);
        arb_mode     = mode_i[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    mode_d  = mode_q;
    iter_d  = '0;
    start_d = 1'b0;
    last_d  = 1'b0;
    done_d  = '0;
    if (clr_i) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      sel_d   = '0;
      grant_d = '0;
      mode_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arb_hit) begin
            state_d = S_RUN;
            sel_d   = arb_sel;
            grant_d = arb_grant;
            mode_d  = arb_mode;
            start_d = 1'b1;
          end
        end
        S_RUN: begin
          if (iter_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = grant_q;
          end else begin
            iter_d = iter_q + 1'b1;
            last_d = (iter_q == PENULT);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          grant_d = '0;
          sel_d   = '0;
          mode_d  = 1'b0;
          ptr_d   = (sel_q == MAX_SEL) ? '0 : sel_q + 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          grant_d = '0;
          sel_d   = '0;
          mode_d  = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      mode_q  <= 1'b0;
      iter_q  <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      mode_q  <= mode_d;
      iter_q  <= iter_d;
      start_q <= start_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // A clear landing on the DONE cycle suppresses the already-registered pulse.
  assign done_o       = done_q & {N_REQ{~clr_i}};
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign core_start_o = start_q;
  assign core_mode_o  = mode_q;
  assign core_sel_o   = sel_q;
  assign iter_idx_o   = iter_q;
  assign core_last_o  = last_q;

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] ops_cnt_q, busy_cnt_q, wait_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt_q  <= '0;
      busy_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else if (clr_i) begin
      ops_cnt_q  <= '0;
      busy_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      if ((|done_o) && (ops_cnt_q != 16'hFFFF))
        ops_cnt_q <= ops_cnt_q + 16'd1;
      if (busy_q && (busy_cnt_q != 16'hFFFF))
        busy_cnt_q <= busy_cnt_q + 16'd1;
      if ((|(req_i & ~grant_q)) && (wait_cnt_q != 16'hFFFF))
        wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign ops_cnt_o  = ops_cnt_q;
  assign busy_cnt_o = busy_cnt_q;
  assign wait_cnt_o = wait_cnt_q;
`endif

endmodule
`default_nettype wire
